sevseg_arbiter: RTL

//  Shares the two-digit seven-segment display between up to four 8-bit value sources:
//  0 = OBUS output register, 1 = PC, 2 = MAR, 3 = bus monitor.

---
 rtl/sevseg_arbiter_if.sv | 20 ++
 rtl/sevseg_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sevseg_arbiter_if.sv
// Bundle of request/value inputs and display-side outputs shared by the
// sevseg_arbiter and the logic that feeds or consumes it.
interface sevseg_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  disp_data;
  logic [1:0]  disp_src;
  logic        disp_vld;

  modport master (
    output req, req_data,
    input  gnt, disp_data, disp_src, disp_vld
  );

  modport slave (
    input  req, req_data,
    output gnt, disp_data, disp_src, disp_vld
  );
endinterface

// File: rtl/sevseg_arbiter.sv
// Round-robin owner selection with minimum dwell for the two-digit display.
// Define SEVSEG_ARB_LOCK_EN to add the 'lock' input that freezes the current owner.
module sevseg_arbiter #(
  parameter int DWELL = 5000000,
  parameter int CW    = 23
) (
  input  logic              clk,
  input  logic              CLR,
`ifdef SEVSEG_ARB_LOCK_EN
  input  logic              lock,
`endif
  sevseg_arbiter_if.slave   arb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    SHARE = 2'd2
  } state_e;

  localparam logic [CW-1:0] DwellLast = CW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    src_q, src_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;

  logic          lock_w;
  logic          found;
  logic [1:0]    winner;
  logic [1:0]    cand;
  logic          owner_req;
  logic          others_req;
  logic          take;

`ifdef SEVSEG_ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif

  // Scan starts just after rr_ptr, so the last winner is considered last.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    cand   = rr_ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!found && arb.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign owner_req  = arb.req[src_q];
  assign others_req = |(arb.req & ~(4'b0001 << src_q));

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    take     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) take = 1'b1;
      end
      OWN, SHARE: begin
        if (!owner_req) begin
          if (found) take = 1'b1;
          else       state_d = IDLE;
        end else if (lock_w) begin
          state_d = state_q;
        end else if (state_q == OWN) begin
          dwell_d = dwell_q + CW'(1);
          if (dwell_q + CW'(1) == DwellLast) state_d = SHARE;
        end else if (others_req) begin
          take = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d  = OWN;
      src_d    = winner;
      rr_ptr_d = winner;
      dwell_d  = '0;
    end

    vld_d  = (state_d != IDLE);
    gnt_d  = vld_d ? (4'b0001 << src_d) : 4'b0000;
    data_d = vld_d ? arb.req_data[{src_d, 3'b000} +: 8] : data_q;
  end

  always_ff @(posedge clk) begin
    if (!CLR) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      rr_ptr_q <= 2'd3;
      src_q    <= 2'd0;
      gnt_q    <= 4'b0000;
      data_q   <= 8'h00;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.disp_data = data_q;
  assign arb.disp_src  = src_q;
  assign arb.disp_vld  = vld_q;

endmodule
